div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO divide path.
- Accepts a divide request from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline through stall_req_o while busy, then presents the 64-bit result {remainder, quotient} for the HI/LO write that EX forwards through MEM/WB.
- Supports signed and unsigned DIV, divide-by-zero, and annulment when the divide sits in a squashed delay slot or branch shadow.

Parameters:
- WIDTH, 32: operand width in bits. Result is 2*WIDTH bits.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  divide request level. Held high by EX until the result is consumed.
- annul_i  in  1  cancel the current or requested divide
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at accept.
- opdata1_i  in  WIDTH  dividend. Sampled at accept.
- opdata2_i  in  WIDTH  divisor. Sampled at accept.
- result_o  out  2*WIDTH  [2W-1:W] = remainder (to HI), [W-1:0] = quotient (to LO). Registered.
- ready_o  out  1  result valid. Registered.
- stall_req_o  out  1  pipeline stall request. Combinational: start_i & ~ready_o & ~annul_i.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=FREE, cnt=0, working regs=0.
  - result_o=0, ready_o=0.
  - Overrides every other input, including mid-operation. Any divide in progress is discarded.
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - On start_i=1 & annul_i=0 at edge E0:
    - Latch signed_div_i.
    - If opdata2_i==0, go to BYZERO.
    - Otherwise go to ON with cnt=0.
    - Load magnitudes: in signed mode a negative operand is replaced by its two's complement; in unsigned mode operands load as-is.
    - Latch sign of dividend and sign of divisor (signed mode only).
  - Otherwise remain in FREE.
- BYZERO:
  - Next edge: result_o=0, ready_o=1, go to END.
  - Division by zero therefore yields HI=0, LO=0, with ready_o visible after E0+1.
- ON:
  - If annul_i=1: go to FREE, cnt=0, ready_o stays 0, result discarded.
  - Else if cnt<WIDTH, perform one iteration, then cnt=cnt+1:
    - partial = remainder_reg - divisor_mag, computed at WIDTH+1 bits.
    - If partial is non-negative: remainder_reg=partial, shift in quotient bit 1.
    - Otherwise: remainder_reg unchanged, shift in quotient bit 0.
    - Remainder is shifted left with the next dividend bit, MSB first.
  - Else (cnt==WIDTH): apply sign fix, write result_o, set ready_o=1, go to END.
    - Quotient is negated iff signed mode and dividend sign != divisor sign.
    - Remainder is negated iff signed mode and dividend negative.
- Latency:
  - Accept at E0; iterations run at E1..E32; result and ready_o are written at E33.
  - ready_o is high from the cycle after E33.
- END:
  - Holds result_o and ready_o=1 while start_i=1.
  - When start_i=0: next edge ready_o=0, result_o=0, go to FREE.
  - annul_i is ignored in END.
- Arithmetic boundary:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. Magnitude arithmetic wraps; no trap.
- Back-to-back: a new request is accepted only from FREE, i.e. start_i must drop for at least one cycle between divides.
- stall_req_o:
  - High from the cycle start_i rises until ready_o is high.
  - Low during an annul cycle.
  - Never high during reset-held FREE unless start_i=1.

Test Plan:
1. Unsigned: opdata1=100, opdata2=7, start held.
   -> stall_req_o=1 through E33, ready_o=1 after E33, result_o={32'd2, 32'd14}; drop start -> next cycle ready_o=0, result_o=0.
2. Signed: -7 / 2, i.e. 0xFFFFFFF9 / 0x00000002.
   -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   Also 7 / -2 -> LO=0xFFFFFFFD, HI=0x00000001.
3. Divide by zero, both modes: opdata2=0.
   -> ready_o=1 after E0+1, result_o=0, stall released one cycle later.
4. Annul: start a divide, assert annul_i at E10.
   -> state FREE, ready_o never rises, stall_req_o=0 during annul; a fresh 100/7 then completes with correct timing (E33 from its accept).
5. Extremes:
   -> signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
   -> unsigned 0xFFFFFFFF / 1 gives LO=0xFFFFFFFF, HI=0.
   -> unsigned 5 / 9 gives LO=0, HI=5.
6. Reset mid-divide: rst=1 at E15.
   -> next cycle ready_o=0, result_o=0, state FREE; with start_i held high after rst drops, a new divide is accepted and completes normally.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for the HI/LO path.
// Accepts a request from EX, stalls the pipeline while iterating, then holds
// {remainder, quotient} until EX drops start_i.
module div_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_req_o
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
   logic               neg1_q, neg1_d;   // dividend was negative (signed mode only)
   logic               neg2_q, neg2_d;   // divisor was negative (signed mode only)
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   diff;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               op1_neg;
   logic               op2_neg;

   // Next-state, datapath and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      result_d = result_q;
      ready_d  = ready_q;

      op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
      op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
      shifted  = {rem_q, quo_q[WIDTH-1]};
      diff     = {1'b0, shifted} - {2'b00, dvs_q};
      quo_fix  = (neg1_q ^ neg2_q) ? ((~quo_q) + WIDTH'(1)) : quo_q;
      rem_fix  = neg1_q ? ((~rem_q) + WIDTH'(1)) : rem_q;

      unique case (state_q)
         ST_FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               neg1_d = op1_neg;
               neg2_d = op2_neg;
               quo_d  = op1_neg ? ((~opdata1_i) + WIDTH'(1)) : opdata1_i;
               dvs_d  = op2_neg ? ((~opdata2_i) + WIDTH'(1)) : opdata2_i;
               rem_d  = '0;
               cnt_d  = '0;
               state_d = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
            end
         end
         ST_BYZERO: begin
            result_d = '0;
            ready_d  = 1'b1;
            state_d  = ST_END;
         end
         ST_ON: begin
            if (annul_i) begin
               cnt_d   = '0;
               ready_d = 1'b0;
               state_d = ST_FREE;
            end else if (cnt_q != CNT_W'(WIDTH)) begin
               if (!diff[WIDTH+1]) begin
                  rem_d = WIDTH'(diff);
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = WIDTH'(shifted);
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
               state_d  = ST_END;
            end
         end
         ST_END: begin
            if (!start_i) begin
               result_d = '0;
               ready_d  = 1'b0;
               state_d  = ST_FREE;
            end
         end
         default: state_d = ST_FREE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o    = result_q;
   assign ready_o     = ready_q;
   assign stall_req_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of the div_ctrl sequencer.
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        annul;
   logic        sdiv;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [63:0] result;
   logic        ready;
   logic        stall;

   int vectors;
   int errs;

   div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .annul_i      (annul),
      .signed_div_i (sdiv),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .result_o     (result),
      .ready_o      (ready),
      .stall_req_o  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full handshake: request, wait for ready, hold, release.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] hi, input logic [31:0] lo,
                          input int lat);
      int   n;
      logic stall_ok;
      op1   = a;
      op2   = b;
      sdiv  = sg;
      start = 1'b1;
      #1;
      chk({tag, "_stall_pre"}, 64'(stall), 64'd1);
      n = 0;
      stall_ok = 1'b1;
      do begin
         tick();
         n++;
         if (!ready && !stall) stall_ok = 1'b0;
      end while (!ready && n < 60);
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      chk({tag, "_result"}, result, {hi, lo});
      chk({tag, "_stall_rel"}, 64'(stall), 64'd0);
      // Operand changes after accept must not disturb the held result.
      op1 = 32'h1234_5678;
      op2 = 32'h0;
      tick();
      chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      chk({tag, "_hold_res"}, result, {hi, lo});
      start = 1'b0;
      tick();
      chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
      chk({tag, "_drop_res"}, result, 64'd0);
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      rst   = 1'b1;
      start = 1'b0;
      annul = 1'b0;
      sdiv  = 1'b0;
      op1   = '0;
      op2   = '0;
      tick();
      tick();
      chk("reset_rdy", 64'(ready), 64'd0);
      chk("reset_res", result, 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      rst = 1'b0;
      tick();
      chk("idle_rdy", 64'(ready), 64'd0);

      // Unsigned and signed arithmetic.
      run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 34);
      run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 34);
      // Unsigned view of the same bits as -7/2: 0xFFFFFFF9/2.
      run_div("u_f9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd1, 32'h7FFF_FFFC, 34);

      // Divide by zero in both modes.
      run_div("u_dz", 32'd55, 32'd0, 1'b0, 32'd0, 32'd0, 2);
      run_div("s_dz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd0, 32'd0, 2);

      // Annul at E10, then a fresh divide.
      op1   = 32'd1000;
      op2   = 32'd3;
      sdiv  = 1'b0;
      start = 1'b1;
      tick();
      repeat (9) tick();
      annul = 1'b1;
      #1;
      chk("annul_stall", 64'(stall), 64'd0);
      tick();
      chk("annul_rdy", 64'(ready), 64'd0);
      annul = 1'b0;
      start = 1'b0;
      repeat (40) tick();
      chk("annul_rdy_late", 64'(ready), 64'd0);
      chk("annul_res_late", result, 64'd0);
      run_div("post_annul", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 34);

      // Extremes.
      run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 34);
      run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 34);
      run_div("u5_9", 32'd5, 32'd9, 1'b0, 32'd5, 32'd0, 34);
      run_div("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 32'd14, 34);

      // Reset at E15 of a running divide; start stays high afterwards.
      op1   = 32'd77;
      op2   = 32'd5;
      sdiv  = 1'b0;
      start = 1'b1;
      tick();
      repeat (14) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_rdy", 64'(ready), 64'd0);
      chk("rst_mid_res", result, 64'd0);
      rst = 1'b0;
      run_div("post_rst", 32'd1000, 32'd3, 1'b0, 32'd1, 32'd333, 34);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
